// File: rtl/register_file_pkg.sv
// Shared constants for the general-purpose register file: geometry and
// named register indices used by the datapath and benches.
package register_file_pkg;

  localparam int RF_NUM_REGS = 16;
  localparam int RF_WIDTH    = 32;
  localparam int RF_ADDR_W   = 4;

  localparam logic [RF_ADDR_W-1:0] REG_SP = 4'd13;
  localparam logic [RF_ADDR_W-1:0] REG_LR = 4'd14;
  localparam logic [RF_ADDR_W-1:0] REG_PC = 4'd15;

endpackage

// File: rtl/register_file_word.sv
// One storage word: load-enabled register with asynchronous active-high clear.
module register_file_word #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Word storage; clear overrides any pending load.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/register_file_write_decoder.sv
// Write-address decoder: ADDR_W-bit address to NUM_REGS-wide one-hot load
// vector, all-zero when the write is not enabled.
module register_file_write_decoder #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic              enable,
  input  logic [ADDR_W-1:0] addr,
  output logic [NUM_REGS-1:0] onehot
);

  // One-hot load vector generation.
  always_comb begin
    onehot = '0;
    if (enable) begin
      onehot[addr] = 1'b1;
    end else begin
      onehot = '0;
    end
  end

endmodule

// File: rtl/register_file.sv
// Sixteen-entry register file: one synchronous write port, three combinational
// read ports with write-first bypass, asynchronous clear of every word.
module register_file
  import register_file_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int WIDTH    = RF_WIDTH,
  parameter int ADDR_W   = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [WIDTH-1:0]  write_data,
  input  logic [ADDR_W-1:0] read_addr_a,
  input  logic [ADDR_W-1:0] read_addr_b,
  input  logic [ADDR_W-1:0] read_addr_c,
  output logic [WIDTH-1:0]  read_data_a,
  output logic [WIDTH-1:0]  read_data_b,
  output logic [WIDTH-1:0]  read_data_c
);

  logic [NUM_REGS-1:0]            load_vec;
  logic [NUM_REGS-1:0][WIDTH-1:0] words;

  // Shared read path: clear forces zero, a same-cycle write to the selected
  // address is forwarded, otherwise the stored word is returned.
  function automatic logic [WIDTH-1:0] read_port(
    input logic [ADDR_W-1:0]              raddr,
    input logic [NUM_REGS-1:0][WIDTH-1:0] store,
    input logic                           clear,
    input logic                           wen,
    input logic [ADDR_W-1:0]              waddr,
    input logic [WIDTH-1:0]               wdata
  );
    logic [WIDTH-1:0] value;
    if (clear) begin
      value = '0;
    end else if (wen && (raddr == waddr)) begin
      value = wdata;
    end else begin
      value = store[raddr];
    end
    return value;
  endfunction

  register_file_write_decoder #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_write_decoder (
    .enable (write_enable),
    .addr   (write_addr),
    .onehot (load_vec)
  );

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_word
    register_file_word #(
      .WIDTH (WIDTH)
    ) u_word (
      .clk  (clk),
      .clr  (clr),
      .load (load_vec[i]),
      .d    (write_data),
      .q    (words[i])
    );
  end

  assign read_data_a = read_port(read_addr_a, words, clr, write_enable, write_addr, write_data);
  assign read_data_b = read_port(read_addr_b, words, clr, write_enable, write_addr, write_data);
  assign read_data_c = read_port(read_addr_c, words, clr, write_enable, write_addr, write_data);

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized
// traffic compared against an array model of the sixteen words.
module tb_register_file;

  logic        clk;
  logic        clr;
  logic        we;
  logic [3:0]  wa;
  logic [31:0] wd;
  logic [3:0]  ra, rb, rc;
  logic [31:0] da, db, dc;

  logic [31:0] model [16];
  int n_cmp;
  int n_err;

  register_file dut (
    .clk          (clk),
    .clr          (clr),
    .write_enable (we),
    .write_addr   (wa),
    .write_data   (wd),
    .read_addr_a  (ra),
    .read_addr_b  (rb),
    .read_addr_c  (rc),
    .read_data_a  (da),
    .read_data_b  (db),
    .read_data_c  (dc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected read value from the specification rules and the word model.
  function automatic logic [31:0] exp_rd(input logic [3:0] addr);
    if (clr) return 32'h0;
    if (we && addr == wa) return wd;
    return model[addr];
  endfunction

  // Advance one rising edge, commit to the model, land mid-cycle.
  task automatic tick();
    @(posedge clk);
    if (we && !clr) model[wa] = wd;
    #2;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
  endtask

  task automatic test_reset();
    clr = 1'b1; we = 1'b1; wa = 4'd3; wd = 32'hDEADBEEF;
    ra = 4'd0; rb = 4'd3; rc = 4'd15;
    clear_model();
    #1;
    n_cmp += 3;
    if (da !== 32'h0) begin n_err++; $display("FAIL reset_a0 got=%h exp=%h", da, 32'h0); end
    if (db !== 32'h0) begin n_err++; $display("FAIL reset_b3 got=%h exp=%h", db, 32'h0); end
    if (dc !== 32'h0) begin n_err++; $display("FAIL reset_c15 got=%h exp=%h", dc, 32'h0); end
    tick();
    tick();
    n_cmp++;
    if (db !== 32'h0) begin n_err++; $display("FAIL reset_held_b3 got=%h exp=%h", db, 32'h0); end
    clr = 1'b0; we = 1'b0;
    #1;
    n_cmp += 2;
    if (db !== 32'h0) begin n_err++; $display("FAIL reset_r3_after got=%h exp=%h", db, 32'h0); end
    if (dc !== 32'h0) begin n_err++; $display("FAIL reset_r15_after got=%h exp=%h", dc, 32'h0); end
  endtask

  task automatic test_write_read();
    we = 1'b1; wa = 4'd1; wd = 32'h0000000A;
    tick();
    wa = 4'd2; wd = 32'h0000000B;
    tick();
    we = 1'b0; ra = 4'd1; rb = 4'd2; rc = 4'd1;
    #1;
    n_cmp += 3;
    if (da !== 32'h0000000A) begin n_err++; $display("FAIL wr_rd_a got=%h exp=%h", da, 32'h0000000A); end
    if (db !== 32'h0000000B) begin n_err++; $display("FAIL wr_rd_b got=%h exp=%h", db, 32'h0000000B); end
    if (dc !== 32'h0000000A) begin n_err++; $display("FAIL wr_rd_c got=%h exp=%h", dc, 32'h0000000A); end
  endtask

  task automatic test_bypass();
    logic [31:0] b_before;
    we = 1'b1; wa = 4'd5; wd = 32'h11111111;
    tick();
    wd = 32'h22222222; ra = 4'd5; rb = 4'd4; rc = 4'd5;
    #1;
    b_before = model[4];
    n_cmp += 2;
    if (da !== 32'h22222222) begin n_err++; $display("FAIL bypass_before got=%h exp=%h", da, 32'h22222222); end
    if (db !== b_before) begin n_err++; $display("FAIL bypass_other got=%h exp=%h", db, b_before); end
    tick();
    we = 1'b0;
    #1;
    n_cmp += 2;
    if (da !== 32'h22222222) begin n_err++; $display("FAIL bypass_after got=%h exp=%h", da, 32'h22222222); end
    if (db !== b_before) begin n_err++; $display("FAIL bypass_other_after got=%h exp=%h", db, b_before); end
  endtask

  task automatic test_write_disabled();
    we = 1'b0; wa = 4'd7; wd = 32'hFFFFFFFF; ra = 4'd7; rb = 4'd7; rc = 4'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (da !== 32'h0) begin n_err++; $display("FAIL wdis_bypass[%0d] got=%h exp=%h", i, da, 32'h0); end
      tick();
    end
    #1;
    n_cmp++;
    if (db !== 32'h0) begin n_err++; $display("FAIL wdis_r7 got=%h exp=%h", db, 32'h0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    we = 1'b1; wa = 4'd9; ra = 4'd9; rb = 4'd9; rc = 4'd9;
    for (int i = 0; i < 3; i++) begin
      v = $urandom;
      wd = v;
      tick();
      #1;
      n_cmp++;
      if (db !== v) begin n_err++; $display("FAIL b2b[%0d] got=%h exp=%h", i, db, v); end
    end
    // Reload of an unchanged value leaves the word intact.
    tick();
    we = 1'b0;
    #1;
    n_cmp++;
    if (dc !== v) begin n_err++; $display("FAIL reload got=%h exp=%h", dc, v); end
  endtask

  task automatic test_sweep();
    logic [31:0] ea, eb, ec;
    we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wa = 4'(i); wd = 32'h100 + 32'(i);
      tick();
    end
    we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ra = 4'(i); rb = 4'(15 - i); rc = 4'((i + 5) % 16);
      ea = 32'h100 + 32'(i);
      eb = 32'h100 + 32'(15 - i);
      ec = 32'h100 + 32'((i + 5) % 16);
      #1;
      n_cmp += 3;
      if (da !== ea) begin n_err++; $display("FAIL sweep_a[%0d] got=%h exp=%h", i, da, ea); end
      if (db !== eb) begin n_err++; $display("FAIL sweep_b[%0d] got=%h exp=%h", i, db, eb); end
      if (dc !== ec) begin n_err++; $display("FAIL sweep_c[%0d] got=%h exp=%h", i, dc, ec); end
    end
  endtask

  task automatic test_mid_reset();
    ra = 4'd0; rb = 4'd15; rc = 4'd6; we = 1'b1; wa = 4'd6; wd = 32'hCAFEF00D;
    clr = 1'b1;
    clear_model();
    #1;
    n_cmp += 3;
    if (da !== 32'h0) begin n_err++; $display("FAIL midrst_a got=%h exp=%h", da, 32'h0); end
    if (db !== 32'h0) begin n_err++; $display("FAIL midrst_b got=%h exp=%h", db, 32'h0); end
    if (dc !== 32'h0) begin n_err++; $display("FAIL midrst_c got=%h exp=%h", dc, 32'h0); end
    tick();
    clr = 1'b0; we = 1'b0;
    #1;
    n_cmp += 2;
    if (dc !== 32'h0) begin n_err++; $display("FAIL midrst_clear_wins got=%h exp=%h", dc, 32'h0); end
    if (db !== 32'h0) begin n_err++; $display("FAIL midrst_r15 got=%h exp=%h", db, 32'h0); end
    we = 1'b1; wa = 4'd6; wd = 32'h0BADC0DE;
    tick();
    we = 1'b0;
    #1;
    n_cmp++;
    if (dc !== 32'h0BADC0DE) begin n_err++; $display("FAIL post_release_write got=%h exp=%h", dc, 32'h0BADC0DE); end
  endtask

  task automatic test_random();
    logic [31:0] ea, eb, ec;
    for (int n = 0; n < 400; n++) begin
      clr = ($urandom_range(0, 31) == 0);
      if (clr) clear_model();
      we = $urandom_range(0, 1);
      wa = 4'($urandom_range(0, 15));
      wd = $urandom;
      ra = 4'($urandom_range(0, 15));
      rb = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      rc = 4'($urandom_range(0, 15));
      #1;
      ea = exp_rd(ra); eb = exp_rd(rb); ec = exp_rd(rc);
      n_cmp += 3;
      if (da !== ea) begin n_err++; $display("FAIL rand_a[%0d] addr=%0d got=%h exp=%h", n, ra, da, ea); end
      if (db !== eb) begin n_err++; $display("FAIL rand_b[%0d] addr=%0d got=%h exp=%h", n, rb, db, eb); end
      if (dc !== ec) begin n_err++; $display("FAIL rand_c[%0d] addr=%0d got=%h exp=%h", n, rc, dc, ec); end
      tick();
    end
    clr = 1'b0; we = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_write_disabled();
    test_back_to_back();
    test_sweep();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
